// File: rtl/lsu_dm.sv
// Load/store unit: drives the data-memory port for one request at a time,
// splitting misaligned halfword/word accesses into sequential byte beats.
module lsu_dm #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        DMWr,
    output logic [2:0]  DMCtrl,
    output logic [31:0] addr,
    output logic [31:0] DataWr,
    input  logic [31:0] DataRd
);

    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  beat_q, beat_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [32:0] req_end;
    logic        req_bad;
    logic [2:0]  size_q;
    logic        misal;
    logic        last_beat;
    logic [31:0] gathered;
    logic [31:0] load_res;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    // Last byte address in 33 bits so a 32-bit wrap also lands out of range.
    always_comb begin
        req_end = {1'b0, req_addr} + {30'b0, size_of(req_funct3)} - 33'd1;
        req_bad = (|(req_end >> ADDR_W)) ||
                  (req_we ? (req_funct3 > 3'd2)
                          : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11));
    end

    always_comb begin
        size_q    = size_of(f3_q);
        misal     = (f3_q[1:0] == 2'b01 && addr_q[0]) ||
                    (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
        last_beat = !misal || ({1'b0, beat_q} == size_q - 3'd1);
        gathered  = {8'b0, asm_q};
        gathered[{beat_q, 3'b000} +: 8] = DataRd[7:0];
        case (f3_q)
            3'b001:  load_res = {{16{gathered[15]}}, gathered[15:0]};
            3'b101:  load_res = {16'b0, gathered[15:0]};
            default: load_res = gathered;
        endcase
    end

    // Memory port depends on registered state only; reset suppresses writes.
    always_comb begin
        DMWr   = 1'b0;
        DMCtrl = 3'b000;
        addr   = '0;
        DataWr = '0;
        if (state_q == BEAT) begin
            DMWr = we_q && rst_n;
            if (misal) begin
                DMCtrl = we_q ? 3'b000 : 3'b100;
                addr   = addr_q + {30'b0, beat_q};
                DataWr = {24'b0, wdata_q[{beat_q, 3'b000} +: 8]};
            end else begin
                DMCtrl = f3_q;
                addr   = addr_q;
                DataWr = wdata_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        beat_d  = beat_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    beat_d  = '0;
                    asm_d   = '0;
                    if (req_bad) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = BEAT;
                    end
                end
            end
            BEAT: begin
                asm_d = gathered[23:0];
                if (last_beat) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : (misal ? load_res : DataRd);
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            beat_q  <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
